sha256_result_checker: RTL

- Synthesizable, parametrised successor to the bench-side expected-hash FIFO and comparator around sha256_double.
- Queues expected hashes, each with a tag, in issue order, and pops one entry per core result.
- Compares each popped entry against the result, keeps saturating pass/fail/orphan counters, and captures the first mismatch.
- Sits beside any fixed-latency hashing pipeline, in silicon self-test or in benches; no $error/$stop.

---
 rtl/sha256_pkg.sv | 14 +
 rtl/sha_fifo_sync.sv | 55 +++++
 rtl/sha256_result_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// sha256_pkg: shared widths and constants for the sha256 core and its result checker.
// Revision 1.0
package sha256_pkg;

  localparam int HASH_WIDTH = 256;

  typedef logic [HASH_WIDTH-1:0] hash_t;

  // Second 512-bit block of an 80-byte header: 128 data bits precede this padding.
  localparam logic [383:0] PAD_640_BLOCK2 = {8'h80, 312'd0, 64'h280};

endpackage
`default_nettype wire

// File: rtl/sha_fifo_sync.sv
`default_nettype none
// sha_fifo_sync: show-ahead synchronous FIFO with occupancy output and push-while-full-and-popping.
// Revision 1.0
module sha_fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/sha256_result_checker.sv
`default_nettype none
// sha256_result_checker: queues tagged expected hashes, compares them with core results in order,
// keeps saturating statistics and captures the first mismatch. Revision 1.0
module sha256_result_checker
  import sha256_pkg::*;
#(
  parameter int HASH_WIDTH      = sha256_pkg::HASH_WIDTH,
  parameter int TAG_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DEPTH_LOG2 = 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [HASH_WIDTH-1:0]      exp_hash,
  input  logic [TAG_WIDTH-1:0]       exp_tag,
  input  logic                       res_valid,
  input  logic [HASH_WIDTH-1:0]      res_hash,
  output logic                       cmp_valid,
  output logic                       cmp_pass,
  output logic [CNT_WIDTH-1:0]       pass_cnt,
  output logic [CNT_WIDTH-1:0]       fail_cnt,
  output logic [CNT_WIDTH-1:0]       orphan_cnt,
  output logic                       error,
  output logic                       overflow,
  output logic [TAG_WIDTH-1:0]       err_tag,
  output logic [HASH_WIDTH-1:0]      err_expected,
  output logic [HASH_WIDTH-1:0]      err_actual,
  output logic [FIFO_DEPTH_LOG2:0]   level
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [TAG_WIDTH+HASH_WIDTH-1:0] head;
  logic [TAG_WIDTH-1:0]            head_tag;
  logic [HASH_WIDTH-1:0]           head_hash;
  logic                            full;
  logic                            empty;
  logic                            pop;
  logic                            match;
  logic                            fail_now;
  logic                            orphan_now;
  logic                            overflow_now;
  logic                            captured;

  sha_fifo_sync #(
    .DATA_WIDTH (TAG_WIDTH + HASH_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (exp_valid),
    .pop   (pop),
    .wdata ({exp_tag, exp_hash}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign {head_tag, head_hash} = head;
  assign exp_ready    = !full;
  assign pop          = res_valid && !empty;
  assign match        = (head_hash == res_hash);
  assign fail_now     = pop && !match;
  // No bypass: a result seen while empty is an orphan even if a push lands this cycle.
  assign orphan_now   = res_valid && empty;
  assign overflow_now = exp_valid && full && !pop;

  // clear shares the reset path here; only the FIFO distinguishes the two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cmp_valid    <= 1'b0;
      cmp_pass     <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      orphan_cnt   <= '0;
      error        <= 1'b0;
      overflow     <= 1'b0;
      captured     <= 1'b0;
      err_tag      <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      cmp_valid <= pop;
      cmp_pass  <= pop && match;
      if (pop && match && pass_cnt != CNT_MAX)     pass_cnt   <= pass_cnt + 1'b1;
      if (fail_now && fail_cnt != CNT_MAX)         fail_cnt   <= fail_cnt + 1'b1;
      if (orphan_now && orphan_cnt != CNT_MAX)     orphan_cnt <= orphan_cnt + 1'b1;
      if (fail_now && !captured) begin
        captured     <= 1'b1;
        err_tag      <= head_tag;
        err_expected <= head_hash;
        err_actual   <= res_hash;
      end
      error    <= error | fail_now | orphan_now | overflow_now;
      overflow <= overflow | overflow_now;
    end
  end

endmodule
`default_nettype wire
